// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
//
// Two-stage pipelined priority compositor for the VGA object path. Each clk
// it takes one pixel's worth of drawing requests and colours from
// NUM_LAYERS object layers, plus a background colour. It outputs the colour
// of the highest-priority visible layer two clocks later. Index 0 has the
// highest priority.
//
// A layer is visible for a pixel only if all of these hold:
//   - it requests the pixel,
//   - it is enabled,
//   - its colour is not the TRANSPARENT key.
// The index of the winning layer is reported alongside the colour.
// NUM_LAYERS means the background won.
//
// A per-frame collision record tracks overlaps between layer 0 (the player)
// and every other layer. It is published on each startOfFrame pulse.
//
// Ports:
//   clk           pixel clock
//   resetN        asynchronous, active-low reset
//   startOfFrame  one-cycle frame-start pulse; closes the current frame
//   layer_en      per-layer enable
//   draw_req      per-layer drawing request for the current pixel
//   rgb_in        packed layer colours, layer i at [i*COLOR_W +: COLOR_W]
//   bg_rgb        background colour
//   rgb_out       composited colour (2 clk latency)
//   win_layer     winning layer index, NUM_LAYERS = background
//   hit_flags     bit i: layer 0 overlapped layer i in last closed frame
//   hit_valid     one-cycle pulse when hit_flags has just been updated
// ---------------------------------------------------------------------------
module layer_compositor #(
    parameter int                  NUM_LAYERS  = 8,
    parameter int                  COLOR_W     = 8,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = 8'hFF,
    localparam int                 IDX_W       = $clog2(NUM_LAYERS + 1)
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS-1:0]         draw_req,
    input  logic [NUM_LAYERS*COLOR_W-1:0] rgb_in,
    input  logic [COLOR_W-1:0]            bg_rgb,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic [IDX_W-1:0]              win_layer,
    output logic [NUM_LAYERS-1:0]         hit_flags,
    output logic                          hit_valid
);

    // ------------------------------------------------------------------
    // Stage 1: effective-draw qualification and input capture
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0]         eff_next;
    logic [NUM_LAYERS-1:0]         eff_s1_reg;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_s1_reg;
    logic [COLOR_W-1:0]            bg_s1_reg;

    // A transparent pixel counts as "not drawn". It neither wins nor
    // collides, even when the layer requests the pixel.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_eff
            assign eff_next[gi] = draw_req[gi] & layer_en[gi] &
                                  (rgb_in[gi*COLOR_W +: COLOR_W] != TRANSPARENT);
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            eff_s1_reg <= '0;
            rgb_s1_reg <= '0;
            bg_s1_reg  <= '0;
        end else begin
            eff_s1_reg <= eff_next;
            rgb_s1_reg <= rgb_in;
            bg_s1_reg  <= bg_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority select (lowest visible index wins)
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] rgb_next;
    logic [IDX_W-1:0]   win_next;

    // Scan from the lowest priority upward so the last match, which is the
    // lowest index, overrides the others.
    always_comb begin
        rgb_next = bg_s1_reg;
        win_next = IDX_W'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_s1_reg[i]) begin
                rgb_next = rgb_s1_reg[i*COLOR_W +: COLOR_W];
                win_next = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_out   <= '0;
            win_layer <= IDX_W'(NUM_LAYERS);
        end else begin
            rgb_out   <= rgb_next;
            win_layer <= win_next;
        end
    end

    // ------------------------------------------------------------------
    // Collision accumulator: player (layer 0) against every other layer
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] hit_now;
    logic [NUM_LAYERS-1:0] acc_reg;
    logic [NUM_LAYERS-1:0] acc_next;

    // Layer 0 cannot collide with itself, so bit 0 is tied low.
    assign hit_now[0] = 1'b0;
    generate
        for (gi = 1; gi < NUM_LAYERS; gi++) begin : g_hit
            assign hit_now[gi] = eff_s1_reg[0] & eff_s1_reg[gi];
        end
    endgenerate

    assign acc_next = acc_reg | hit_now;

    // On a frame close, the current cycle's overlap still belongs to the
    // closing frame. The accumulator then restarts empty for the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_reg   <= '0;
            hit_flags <= '0;
            hit_valid <= 1'b0;
        end else if (startOfFrame) begin
            hit_flags <= acc_next;
            acc_reg   <= '0;
            hit_valid <= 1'b1;
        end else begin
            acc_reg   <= acc_next;
            hit_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_layer_compositor
//
// Directed stimulus with hand-computed expectations. Each driven pixel
// pushes its expected {rgb, win_layer} onto a queue, tagged with the cycle
// it is due. Each frame close pushes its expected hit_flags. Independent
// monitors pop and compare on every output cycle and on every hit_valid.
//
// Layer colours are fixed for the whole run:
//   L0=40  L1=03  L2=E0  L3=FF(transparent)  L4=24  L5=55  L6=66  L7=77
// ---------------------------------------------------------------------------
module tb_layer_compositor;

    localparam int NL = 8;
    localparam int CW = 8;
    localparam int IW = 4;

    logic              clk          = 1'b0;
    logic              resetN       = 1'b0;
    logic              startOfFrame = 1'b0;
    logic [NL-1:0]     layer_en     = 8'hFF;
    logic [NL-1:0]     draw_req     = 8'h00;
    logic [NL*CW-1:0]  rgb_in       = 64'h7766_5524_FFE0_0340;
    logic [CW-1:0]     bg_rgb       = 8'h1C;
    logic [CW-1:0]     rgb_out;
    logic [IW-1:0]     win_layer;
    logic [NL-1:0]     hit_flags;
    logic              hit_valid;

    layer_compositor #(
        .NUM_LAYERS  (NL),
        .COLOR_W     (CW),
        .TRANSPARENT (8'hFF)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .layer_en     (layer_en),
        .draw_req     (draw_req),
        .rgb_in       (rgb_in),
        .bg_rgb       (bg_rgb),
        .rgb_out      (rgb_out),
        .win_layer    (win_layer),
        .hit_flags    (hit_flags),
        .hit_valid    (hit_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int             due;
        logic [CW-1:0]  rgb;
        logic [IW-1:0]  win;
        int             id;
    } pix_t;

    pix_t           pix_q[$];
    logic [NL-1:0]  hit_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, id, act, exp);
        end else begin
            $display("ok   %s (vec %0d): %0h", name, id, act);
        end
    endtask

    // Pixel monitor: compares the entry that is due on this cycle.
    pix_t mon_p;
    always @(negedge clk) begin
        if (resetN && pix_q.size() > 0 && pix_q[0].due == cyc) begin
            mon_p = pix_q.pop_front();
            check("rgb_out",   mon_p.id, 32'(rgb_out),   32'(mon_p.rgb));
            check("win_layer", mon_p.id, 32'(win_layer), 32'(mon_p.win));
        end
    end

    // Collision monitor: every hit_valid pulse must match a queued close.
    int hit_n = 0;
    always @(negedge clk) begin
        if (resetN && hit_valid) begin
            hit_n++;
            if (hit_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL hit_valid (close %0d): got unexpected pulse, expected none", hit_n);
            end else begin
                check("hit_flags", hit_n, 32'(hit_flags), 32'(hit_q.pop_front()));
            end
        end
    end

    // Apply one pixel. The expected output is due two edges after sampling.
    task automatic drive(input int id, input logic sof, input logic [NL-1:0] en,
                         input logic [NL-1:0] req, input logic [CW-1:0] exp_rgb,
                         input logic [IW-1:0] exp_win, input logic [NL-1:0] exp_hit);
        pix_t p;
        @(negedge clk);
        startOfFrame = sof;
        layer_en     = en;
        draw_req     = req;
        p.due = cyc + 2;
        p.rgb = exp_rgb;
        p.win = exp_win;
        p.id  = id;
        pix_q.push_back(p);
        if (sof) hit_q.push_back(exp_hit);
    endtask

    // Release reset at a negedge. Stage 2 first shows the cleared stage-1
    // registers, then the idle background.
    task automatic release_reset(input int id);
        pix_t p;
        @(negedge clk);
        resetN = 1'b1;
        p.due = cyc + 1; p.rgb = 8'h00; p.win = 4'd8; p.id = id;
        pix_q.push_back(p);
        p.due = cyc + 2; p.rgb = 8'h1C; p.win = 4'd8; p.id = id;
        pix_q.push_back(p);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rgb_out",   0, 32'(rgb_out),   32'h00);
        check("rst_win_layer", 0, 32'(win_layer), 32'd8);
        check("rst_hit_flags", 0, 32'(hit_flags), 32'h00);
        check("rst_hit_valid", 0, 32'(hit_valid), 32'h0);
        release_reset(0);

        //    id sof  en     req    rgb    win  hit
        drive( 1, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00); // background
        drive( 2, 0, 8'hFF, 8'h06, 8'h03, 4'd1, 8'h00); // L1 over L2
        drive( 3, 0, 8'hFD, 8'h06, 8'hE0, 4'd2, 8'h00); // L1 disabled
        drive( 4, 0, 8'hFF, 8'h28, 8'h55, 4'd5, 8'h00); // L3 transparent
        drive( 5, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        drive( 6, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00); // close: no overlap
        drive( 7, 0, 8'hFF, 8'h11, 8'h40, 4'd0, 8'h00); // L0 & L4 overlap
        drive( 8, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        drive( 9, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h10); // close: bit 4
        drive(10, 0, 8'hFF, 8'h20, 8'h55, 4'd5, 8'h00);
        drive(11, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00); // close: none
        drive(12, 0, 8'hFF, 8'h05, 8'h40, 4'd0, 8'h00); // L0 & L2 overlap
        // This overlap sits in stage 1 on the closing edge, so it is
        // counted in this frame.
        drive(13, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h04);
        drive(14, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        drive(15, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00); // new frame was empty
        drive(16, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00); // back-to-back close
        drive(17, 0, 8'hEF, 8'h11, 8'h40, 4'd0, 8'h00); // L4 disabled
        drive(18, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        drive(19, 0, 8'hFF, 8'hFF, 8'h40, 4'd0, 8'h00); // all request
        drive(20, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'hF6); // all but L0/L3
        drive(21, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        drive(22, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        check("hit_flags_hold", 22, 32'(hit_flags), 32'hF6);

        // Mid-frame reset after a 0/6 overlap has reached the accumulator.
        drive(23, 0, 8'hFF, 8'h41, 8'h40, 4'd0, 8'h00);
        drive(24, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        drive(25, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        #2;
        resetN = 1'b0;
        pix_q.delete();
        #1;
        check("mid_rst_rgb_out",   25, 32'(rgb_out),   32'h00);
        check("mid_rst_win_layer", 25, 32'(win_layer), 32'd8);
        check("mid_rst_hit_flags", 25, 32'(hit_flags), 32'h00);
        check("mid_rst_hit_valid", 25, 32'(hit_valid), 32'h0);
        draw_req = 8'h00;
        startOfFrame = 1'b0;
        @(negedge clk);
        release_reset(26);
        drive(27, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        drive(28, 1, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00); // overlap discarded
        drive(29, 0, 8'hFF, 8'h00, 8'h1C, 4'd8, 8'h00);
        repeat (4) @(negedge clk);

        check("pix_queue_drained", 99, 32'(pix_q.size()), 32'd0);
        check("hit_queue_drained", 99, 32'(hit_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
